trap_sequencer: RTL
===================

Name: trap_sequencer

Overview:
- Machine-mode control FSM for the single-issue RV32I core.
- Consumes the instruction decoder's exception flags (illegal instruction, misaligned load/store) plus the fetch-misalignment flag, the SYSTEM-instruction fields, and the machine interrupt enable/pending bits.
- Sequences reset, trap entry, MRET return and WFI sleep.
- Drives PC-source select, pipeline flush, CSR update strobes and the trap_taken signal back to the decoder.

Parameters:
- none (cause codes and PC-select encodings fixed below)

Ports:
- clk_in  input  1  core clock
- rst_in  input  1  synchronous reset, active-high
- stall_in  input  1  pipeline stall (memory wait); freezes FSM
- illegal_instr_in  input  1  from decoder
- misaligned_load_in  input  1  from decoder
- misaligned_store_in  input  1  from decoder
- misaligned_instr_in  input  1  branch/jump target not 4-byte aligned
- opcode_6_to_2_in  input  5  instr[6:2]
- funct3_in  input  3  instr[14:12]
- funct12_in  input  12  instr[31:20]
- mie_in  input  1  mstatus.MIE
- meie_in, mtie_in, msie_in  input  1 each  mie CSR enable bits
- meip_in, mtip_in, msip_in  input  1 each  pending interrupt lines
- pc_src_out  output  2  00 boot addr, 01 mtvec, 10 mepc, 11 next PC
- flush_out  output  1  kill instruction in decode/execute
- trap_taken_out  output  1  trap entry in progress
- set_epc_out  output  1  write mepc
- set_cause_out  output  1  write mcause
- i_or_e_out  output  1  mcause[31]: 1 interrupt, 0 exception
- cause_out  output  4  mcause[3:0]
- mie_clear_out  output  1  MPIE<=MIE, MIE<=0
- mie_set_out  output  1  MIE<=MPIE, MPIE<=1
- instret_inc_out  output  1  retire strobe
- halt_out  output  1  freeze fetch (WFI)

Behaviour:
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN, WFI. Moore outputs decoded from state. cause_out and i_or_e_out are registered.
- Reset (rst_in=1 at posedge): state<=RESET, cause<=0, i_or_e<=0.
- RESET outputs: pc_src=00, flush=1; all other outputs 0. Next state OPERATING unconditionally after one cycle.
- SYSTEM decode: opcode_6_to_2_in==5'b11100 and funct3==000.
  - ecall: funct12=0x000
  - ebreak: funct12=0x001
  - mret: funct12=0x302
  - wfi: funct12=0x105
  - Any other funct12 with funct3==000 is not special (decoder flags it where applicable).
- Exception priority (highest first), with cause code:
  - misaligned_instr: 0
  - illegal: 2
  - ebreak: 3
  - ecall: 11
  - misaligned_load: 4
  - misaligned_store: 6
- Interrupts are considered only when no exception is present and mie_in=1. Priority and cause code:
  - MEI (meip&meie): 11
  - MSI (msip&msie): 3
  - MTI (mtip&mtie): 7
- OPERATING: pc_src=11, halt=0, flush=0. When stall_in=1: no transition, instret_inc=0. When stall_in=0, first match wins:
  - exception -> TRAP_TAKEN, latch cause, i_or_e=0
  - enabled interrupt -> TRAP_TAKEN, latch cause, i_or_e=1
  - mret -> TRAP_RETURN
  - wfi -> WFI
  - else stay
- instret_inc_out=1 in OPERATING iff stall_in=0 and no exception and no interrupt taken. mret and wfi do retire.
- TRAP_TAKEN outputs: pc_src=01, flush=1, trap_taken=1. set_epc, set_cause and mie_clear are asserted only when stall_in=0. Held while stall_in=1; -> OPERATING when stall_in=0.
- TRAP_RETURN outputs: pc_src=10, flush=1, mie_set=(~stall_in). Held while stall_in=1; -> OPERATING when stall_in=0.
- WFI outputs: halt=1, pc_src=11, flush=0. Wakes on any (xip&xie), regardless of mie_in:
  - mie_in=1 -> TRAP_TAKEN with interrupt cause (same priority), i_or_e=1
  - mie_in=0 -> OPERATING
  - No wake condition: stay.
  - stall_in is ignored in WFI.
- Simultaneous events:
  - Exception plus interrupt: the exception wins; the interrupt is re-evaluated next OPERATING cycle.
  - Exception on an mret/wfi encoding: the exception wins.
- cause_out/i_or_e_out hold their value until the next trap entry.
- rst_in overrides any state, including mid-TRAP_TAKEN or WFI.

Test Plan:
- Reset pulse, then idle inputs -> 1 cycle pc_src=00, flush=1, then pc_src=11, instret_inc=1 each cycle; cause_out=0.
- illegal_instr_in=1 in OPERATING -> next cycle TRAP_TAKEN: pc_src=01, flush=1, set_epc=set_cause=mie_clear=1, cause_out=2, i_or_e=0; following cycle OPERATING; instret_inc=0 on the faulting cycle.
- mie_in=1, meip=mtip=1, meie=mtie=1, misaligned_load=1 in one cycle -> cause 4 (exception); next OPERATING cycle with load cleared -> cause 11, i_or_e=1.
- mret (opcode 11100, funct3 000, funct12 0x302) -> TRAP_RETURN: pc_src=10, flush=1, mie_set=1; held 3 cycles with stall_in=1 and mie_set=0 during the stall.
- wfi with mie_in=0, then mtip=mtie=1 after 5 cycles -> halt=1 for 5 cycles, then OPERATING with no trap. Repeat with mie_in=1 -> TRAP_TAKEN, cause 7, i_or_e=1.
- rst_in asserted during TRAP_TAKEN with stall_in=1 -> next cycle RESET, pc_src=00, trap_taken=0, cause_out=0.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer for the single-issue RV32I core: sequences reset,
// trap entry, MRET return and WFI sleep, and drives PC select, flush and CSR strobes.
module trap_sequencer (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        illegal_instr_in,
    input  logic        misaligned_load_in,
    input  logic        misaligned_store_in,
    input  logic        misaligned_instr_in,
    input  logic [4:0]  opcode_6_to_2_in,
    input  logic [2:0]  funct3_in,
    input  logic [11:0] funct12_in,
    input  logic        mie_in,
    input  logic        meie_in,
    input  logic        mtie_in,
    input  logic        msie_in,
    input  logic        meip_in,
    input  logic        mtip_in,
    input  logic        msip_in,
    output logic [1:0]  pc_src_out,
    output logic        flush_out,
    output logic        trap_taken_out,
    output logic        set_epc_out,
    output logic        set_cause_out,
    output logic        i_or_e_out,
    output logic [3:0]  cause_out,
    output logic        mie_clear_out,
    output logic        mie_set_out,
    output logic        instret_inc_out,
    output logic        halt_out,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_OPERATING   = 3'd1,
        ST_TRAP_TAKEN  = 3'd2,
        ST_TRAP_RETURN = 3'd3,
        ST_WFI         = 3'd4
    } state_t;

    localparam logic [1:0] PC_BOOT  = 2'b00;
    localparam logic [1:0] PC_MTVEC = 2'b01;
    localparam logic [1:0] PC_MEPC  = 2'b10;
    localparam logic [1:0] PC_NEXT  = 2'b11;

    localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK           = 4'd3;
    localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
    localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
    localparam logic [3:0] CAUSE_ECALL            = 4'd11;
    localparam logic [3:0] CAUSE_MSI              = 4'd3;
    localparam logic [3:0] CAUSE_MTI              = 4'd7;
    localparam logic [3:0] CAUSE_MEI              = 4'd11;

    localparam logic [4:0]  OPC_SYSTEM  = 5'b11100;
    localparam logic [11:0] F12_ECALL   = 12'h000;
    localparam logic [11:0] F12_EBREAK  = 12'h001;
    localparam logic [11:0] F12_MRET    = 12'h302;
    localparam logic [11:0] F12_WFI     = 12'h105;

    state_t     state;
    logic [3:0] cause;
    logic       i_or_e;

    logic       is_system;
    logic       is_ecall;
    logic       is_ebreak;
    logic       is_mret;
    logic       is_wfi;
    logic       exc_present;
    logic [3:0] exc_cause;
    logic       irq_mei;
    logic       irq_msi;
    logic       irq_mti;
    logic       irq_any;
    logic [3:0] irq_cause;
    logic       irq_take;

    assign is_system = (opcode_6_to_2_in == OPC_SYSTEM) && (funct3_in == 3'b000);
    assign is_ecall  = is_system && (funct12_in == F12_ECALL);
    assign is_ebreak = is_system && (funct12_in == F12_EBREAK);
    assign is_mret   = is_system && (funct12_in == F12_MRET);
    assign is_wfi    = is_system && (funct12_in == F12_WFI);

    assign exc_present = misaligned_instr_in | illegal_instr_in | is_ebreak |
                         is_ecall | misaligned_load_in | misaligned_store_in;

    always_comb begin
        exc_cause = CAUSE_MISALIGNED_STORE;
        if (misaligned_instr_in)     exc_cause = CAUSE_MISALIGNED_INSTR;
        else if (illegal_instr_in)   exc_cause = CAUSE_ILLEGAL;
        else if (is_ebreak)          exc_cause = CAUSE_EBREAK;
        else if (is_ecall)           exc_cause = CAUSE_ECALL;
        else if (misaligned_load_in) exc_cause = CAUSE_MISALIGNED_LOAD;
    end

    assign irq_mei = meip_in & meie_in;
    assign irq_msi = msip_in & msie_in;
    assign irq_mti = mtip_in & mtie_in;
    assign irq_any = irq_mei | irq_msi | irq_mti;

    always_comb begin
        irq_cause = CAUSE_MTI;
        if (irq_mei)      irq_cause = CAUSE_MEI;
        else if (irq_msi) irq_cause = CAUSE_MSI;
    end

    // An exception always masks a simultaneous interrupt; the interrupt stays
    // pending and is picked up on the next unstalled OPERATING cycle.
    assign irq_take = ~exc_present & mie_in & irq_any;

    // stall_in acts as a "not ready" from the memory side: OPERATING and the
    // trap/return states only advance on a cycle where stall_in is low, and the
    // CSR strobes fire on that same cycle. WFI ignores the stall entirely.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= ST_RESET;
            cause  <= 4'd0;
            i_or_e <= 1'b0;
        end else begin
            case (state)
                ST_RESET: state <= ST_OPERATING;
                ST_OPERATING: begin
                    if (!stall_in) begin
                        if (exc_present) begin
                            state  <= ST_TRAP_TAKEN;
                            cause  <= exc_cause;
                            i_or_e <= 1'b0;
                        end else if (irq_take) begin
                            state  <= ST_TRAP_TAKEN;
                            cause  <= irq_cause;
                            i_or_e <= 1'b1;
                        end else if (is_mret) begin
                            state <= ST_TRAP_RETURN;
                        end else if (is_wfi) begin
                            state <= ST_WFI;
                        end
                    end
                end
                ST_TRAP_TAKEN: begin
                    if (!stall_in) state <= ST_OPERATING;
                end
                ST_TRAP_RETURN: begin
                    if (!stall_in) state <= ST_OPERATING;
                end
                ST_WFI: begin
                    // Wake ignores mstatus.MIE; MIE only decides trap vs resume.
                    if (irq_any) begin
                        if (mie_in) begin
                            state  <= ST_TRAP_TAKEN;
                            cause  <= irq_cause;
                            i_or_e <= 1'b1;
                        end else begin
                            state <= ST_OPERATING;
                        end
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

    always_comb begin
        pc_src_out      = PC_NEXT;
        flush_out       = 1'b0;
        trap_taken_out  = 1'b0;
        set_epc_out     = 1'b0;
        set_cause_out   = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        halt_out        = 1'b0;
        case (state)
            ST_RESET: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
            ST_OPERATING: begin
                instret_inc_out = ~stall_in & ~exc_present & ~irq_take;
            end
            ST_TRAP_TAKEN: begin
                pc_src_out     = PC_MTVEC;
                flush_out      = 1'b1;
                trap_taken_out = 1'b1;
                set_epc_out    = ~stall_in;
                set_cause_out  = ~stall_in;
                mie_clear_out  = ~stall_in;
            end
            ST_TRAP_RETURN: begin
                pc_src_out  = PC_MEPC;
                flush_out   = 1'b1;
                mie_set_out = ~stall_in;
            end
            ST_WFI: begin
                halt_out = 1'b1;
            end
            default: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
        endcase
    end

    assign cause_out  = cause;
    assign i_or_e_out = i_or_e;
    assign dbg_state  = state;

endmodule
